// File: rtl/ime_pkg.sv
// ime_pkg: partition indexing and 4x4 membership shared by the IME SAD tree.
package ime_pkg;
  localparam int NUM_PART = 41;
  typedef enum logic [5:0] {
    P16x16, P16x8_0, P16x8_1, P8x16_0, P8x16_1,
    P8x8_0, P8x8_1, P8x8_2, P8x8_3,
    P8x4_0, P8x4_1, P8x4_2, P8x4_3, P8x4_4, P8x4_5, P8x4_6, P8x4_7,
    P4x8_0, P4x8_1, P4x8_2, P4x8_3, P4x8_4, P4x8_5, P4x8_6, P4x8_7,
    P4x4_0, P4x4_1, P4x4_2, P4x4_3, P4x4_4, P4x4_5, P4x4_6, P4x4_7,
    P4x4_8, P4x4_9, P4x4_10, P4x4_11, P4x4_12, P4x4_13, P4x4_14, P4x4_15
  } part_e;
  // 4x4 blocks are numbered 4*quadrant+sub, the same order as P4x4_*
  function automatic logic [15:0] part_mask(input int p);
    if (p == int'(P16x16)) return 16'hFFFF;
    if (p <= int'(P16x8_1)) return p == int'(P16x8_0) ? 16'h00FF : 16'hFF00;
    if (p <= int'(P8x16_1)) return p == int'(P8x16_0) ? 16'h0F0F : 16'hF0F0;
    if (p <= int'(P8x8_3)) return 16'h000F << (4 * (p - int'(P8x8_0)));
    if (p <= int'(P8x4_7))
      return (((p - int'(P8x4_0)) % 2 != 0) ? 16'h000C : 16'h0003) << (4 * ((p - int'(P8x4_0)) / 2));
    if (p <= int'(P4x8_7))
      return (((p - int'(P4x8_0)) % 2 != 0) ? 16'h000A : 16'h0005) << (4 * ((p - int'(P4x8_0)) / 2));
    return 16'h0001 << (p - int'(P4x4_0));
  endfunction
endpackage

// File: rtl/ime_sad4x4.sv
// ime_sad4x4: registered sum of absolute differences over one 4x4 pixel block.
module ime_sad4x4 #(
  parameter int PIX_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0][PIX_W-1:0] cur_i,
  input  logic [15:0][PIX_W-1:0] ref_i,
  output logic [PIX_W+3:0]       sad_o
);
  logic [PIX_W+3:0] sad_d, sad_q;
  always_comb begin
    sad_d = '0;
    for (int i = 0; i < 16; i++)
      sad_d = sad_d + {4'b0, cur_i[i] > ref_i[i] ? cur_i[i] - ref_i[i] : ref_i[i] - cur_i[i]};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sad_q <= '0;
    else sad_q <= sad_d;
  end
  assign sad_o = sad_q;
endmodule

// File: rtl/ime_sad_tree_min.sv
// ime_sad_tree_min: 3-stage 41-partition SAD engine tracking the best MV per partition.
// Define IME_MVCOST_EN to add the lambda port and a saturating lambda*(|mvx|+|mvy|) cost.
module ime_sad_tree_min
  import ime_pkg::*;
#(
  parameter int PIX_W    = 8,
  parameter int MV_W     = 7,
  parameter int LAMBDA_W = 4,
  parameter int SAD_W    = PIX_W + 8,
  parameter int COST_W   = SAD_W + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic                            in_first,
  input  logic                            in_last,
  input  logic [MV_W-1:0]                 in_mvx,
  input  logic [MV_W-1:0]                 in_mvy,
  input  logic [15:0][15:0][PIX_W-1:0]    cur,
  input  logic [15:0][15:0][PIX_W-1:0]    ref_mb,
`ifdef IME_MVCOST_EN
  input  logic [LAMBDA_W-1:0]             lambda,
`endif
  output logic [NUM_PART-1:0][COST_W-1:0] best_cost,
  output logic [NUM_PART-1:0][MV_W-1:0]   best_mvx,
  output logic [NUM_PART-1:0][MV_W-1:0]   best_mvy,
  output logic                            done
);
  logic v1_q, f1_q, l1_q, v2_q, f2_q, l2_q, done_q;
  logic [MV_W-1:0] mvx1_q, mvy1_q, mvx2_q, mvy2_q;
  logic [PIX_W+3:0] s1 [16];
  logic [COST_W-1:0] cost2_d [NUM_PART];
  logic [COST_W-1:0] cost2_q [NUM_PART];
  logic [NUM_PART-1:0][COST_W-1:0] best_cost_d, best_cost_q;
  logic [NUM_PART-1:0][MV_W-1:0] best_mvx_d, best_mvx_q, best_mvy_d, best_mvy_q;

  for (genvar b = 0; b < 16; b++) begin : g_blk
    localparam int R0 = 8 * (b / 8) + 4 * ((b % 4) / 2);
    localparam int C0 = 8 * ((b / 4) % 2) + 4 * (b % 2);
    logic [15:0][PIX_W-1:0] cb, rb;
    for (genvar i = 0; i < 16; i++) begin : g_px
      assign cb[i] = cur[R0 + i / 4][C0 + i % 4];
      assign rb[i] = ref_mb[R0 + i / 4][C0 + i % 4];
    end
    ime_sad4x4 #(.PIX_W(PIX_W)) u_sad (.clk(clk), .rst(rst), .cur_i(cb), .ref_i(rb), .sad_o(s1[b]));
  end

`ifdef IME_MVCOST_EN
  localparam int MVC_W = LAMBDA_W + MV_W + 2;
  localparam int EXT_W = COST_W + MVC_W;
  localparam logic [COST_W-1:0] COST_MAX = '1;
  logic [LAMBDA_W-1:0] lam1_q;
  logic [MV_W+1:0] ax, ay;
  logic [MVC_W-1:0] mvc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lam1_q <= '0;
    else lam1_q <= lambda;
  end
  // two guard bits so that |-2^(MV_W-1)| is representable
  assign ax = mvx1_q[MV_W-1] ? -{2'b11, mvx1_q} : {2'b00, mvx1_q};
  assign ay = mvy1_q[MV_W-1] ? -{2'b11, mvy1_q} : {2'b00, mvy1_q};
  assign mvc = MVC_W'(lam1_q) * MVC_W'(ax + ay);
`endif

  for (genvar p = 0; p < NUM_PART; p++) begin : g_part
    localparam logic [15:0] M = part_mask(p);
    logic [SAD_W-1:0] sad;
    always_comb begin
      sad = '0;
      for (int b = 0; b < 16; b++) sad = sad + (M[b] ? SAD_W'(s1[b]) : '0);
    end
`ifdef IME_MVCOST_EN
    logic [EXT_W-1:0] ext;
    assign ext = EXT_W'(sad) + EXT_W'(mvc);
    assign cost2_d[p] = ext > EXT_W'(COST_MAX) ? COST_MAX : ext[COST_W-1:0];
`else
    assign cost2_d[p] = COST_W'(sad);
`endif
  end

  always_comb begin
    best_cost_d = best_cost_q;
    best_mvx_d = best_mvx_q;
    best_mvy_d = best_mvy_q;
    for (int p = 0; p < NUM_PART; p++)
      if (v2_q && (f2_q || cost2_q[p] < best_cost_q[p])) begin
        best_cost_d[p] = cost2_q[p];
        best_mvx_d[p] = mvx2_q;
        best_mvy_d[p] = mvy2_q;
      end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {v1_q, f1_q, l1_q, v2_q, f2_q, l2_q, done_q} <= '0;
      {mvx1_q, mvy1_q, mvx2_q, mvy2_q} <= '0;
      cost2_q <= '{default: '0};
      best_cost_q <= '1;
      best_mvx_q <= '0;
      best_mvy_q <= '0;
    end else begin
      v1_q <= in_valid;
      f1_q <= in_valid & in_first;
      l1_q <= in_valid & in_last;
      mvx1_q <= in_mvx;
      mvy1_q <= in_mvy;
      v2_q <= v1_q;
      f2_q <= f1_q;
      l2_q <= l1_q;
      mvx2_q <= mvx1_q;
      mvy2_q <= mvy1_q;
      cost2_q <= cost2_d;
      best_cost_q <= best_cost_d;
      best_mvx_q <= best_mvx_d;
      best_mvy_q <= best_mvy_d;
      done_q <= v2_q & l2_q;
    end
  end

  assign best_cost = best_cost_q;
  assign best_mvx = best_mvx_q;
  assign best_mvy = best_mvy_q;
  assign done = done_q;
endmodule

// File: tb/tb_ime_sad_tree_min.sv
// tb_ime_sad_tree_min: directed checks of the SAD tree, best-MV tracking, timing and reset.
module tb_ime_sad_tree_min;
  import ime_pkg::*;
  localparam int PIX_W = 8, MV_W = 7, LAMBDA_W = 4, COST_W = PIX_W + 9;
`ifdef IME_MVCOST_EN
  localparam bit MVC_ON = 1'b1;
`else
  localparam bit MVC_ON = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0;
  logic [MV_W-1:0] in_mvx = '0, in_mvy = '0;
  logic [15:0][15:0][PIX_W-1:0] cur = '0, ref_mb = '0;
  logic [LAMBDA_W-1:0] lambda = '0;
  logic [NUM_PART-1:0][COST_W-1:0] best_cost;
  logic [NUM_PART-1:0][MV_W-1:0] best_mvx, best_mvy;
  logic done;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  ime_sad_tree_min dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .in_mvx(in_mvx), .in_mvy(in_mvy), .cur(cur), .ref_mb(ref_mb),
`ifdef IME_MVCOST_EN
    .lambda(lambda),
`endif
    .best_cost(best_cost), .best_mvx(best_mvx), .best_mvy(best_mvy), .done(done)
  );

  function automatic logic [MV_W-1:0] mv(input int v);
    return MV_W'(v);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input int cv, input int rv, input int tl);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        cur[r][c] = PIX_W'(cv);
        ref_mb[r][c] = PIX_W'(rv + ((r < 4 && c < 4) ? tl : 0));
      end
  endtask

  task automatic beat(input logic f, input logic l, input int mx, input int my,
                      input int cv, input int rv, input int tl);
    @(negedge clk);
    fill(cv, rv, tl);
    in_valid = 1'b1; in_first = f; in_last = l;
    in_mvx = mv(mx); in_mvy = mv(my);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    for (int p = 0; p < NUM_PART; p++) chk($sformatf("rst_cost%0d", p), best_cost[p], 32'h1FFFF);
    chk("rst_mvx0", best_mvx[0], 0);
    chk("rst_mvy40", best_mvy[40], 0);
    chk("rst_done", done, 0);
    @(negedge clk) rst = 1'b0;

    // single-beat search, zero SAD
    beat(1, 1, 0, 0, 10, 10, 0);
    idle(); step();
    chk("t2_done_k1", done, 0);
    step();
    chk("t2_done_k2", done, 1);
    for (int p = 0; p < NUM_PART; p++) chk($sformatf("t2_cost%0d", p), best_cost[p], 0);
    step();
    chk("t2_done_k3", done, 0);

    // two-beat search; partitions split between candidates
    beat(1, 0, 1, 0, 10, 11, 0);
    beat(0, 1, -2, 3, 10, 10, 5);
    idle(); step();
    chk("t3_done_early", done, 0);
    step();
    chk("t3_done", done, 1);
    chk("t3_c25", best_cost[25], 16);  chk("t3_x25", best_mvx[25], mv(1));  chk("t3_y25", best_mvy[25], mv(0));
    chk("t3_c26", best_cost[26], 0);   chk("t3_x26", best_mvx[26], mv(-2)); chk("t3_y26", best_mvy[26], mv(3));
    chk("t3_c5", best_cost[5], 64);    chk("t3_x5", best_mvx[5], mv(1));
    chk("t3_c0", best_cost[0], 80);    chk("t3_x0", best_mvx[0], mv(-2));   chk("t3_y0", best_mvy[0], mv(3));
    chk("t3_c1", best_cost[1], 80);    chk("t3_c9", best_cost[9], 32);      chk("t3_x9", best_mvx[9], mv(1));
    chk("t3_c17", best_cost[17], 32);  chk("t3_c40", best_cost[40], 0);     chk("t3_x40", best_mvx[40], mv(-2));
    step();
    chk("t3_done_after", done, 0);

    // ties keep earliest; a new search starts right behind it
    beat(1, 0, 4, 4, 10, 10, 0);
    beat(0, 0, 0, 0, 10, 10, 0);
    beat(0, 1, 1, 1, 10, 10, 0);
    beat(1, 1, 5, 5, 20, 20, 0);
    idle(); step();
    chk("t4_done_a", done, 1);
    for (int p = 0; p < NUM_PART; p += 8) begin
      chk($sformatf("t4_x%0d", p), best_mvx[p], mv(4));
      chk($sformatf("t4_y%0d", p), best_mvy[p], mv(4));
    end
    step();
    chk("t4_done_b", done, 1);
    chk("t4_x_new", best_mvx[0], mv(5));
    chk("t4_y_new", best_mvy[40], mv(5));
    step();
    chk("t4_done_end", done, 0);

    // maximum SAD, no wrap
    beat(1, 1, 0, 0, 255, 0, 0);
    idle(); step(); step();
    chk("t5_c0", best_cost[0], 65280);
    chk("t5_c5", best_cost[5], 16320);
    chk("t5_c25", best_cost[25], 4080);
    chk("t5_c1", best_cost[1], 32640);

    // MV cost: 2*(3+1) on zero SAD
    lambda = 4'd2;
    beat(1, 1, 3, -1, 10, 10, 0);
    idle(); step(); step();
    chk("t5_mvc", best_cost[0], MVC_ON ? 8 : 0);
    chk("t5_mvc_y", best_mvy[0], mv(-1));
    beat(1, 0, 3, -1, 10, 10, 0);
    beat(0, 1, 0, 0, 10, 10, 0);
    idle(); step(); step();
    chk("t5_win_c", best_cost[0], 0);
    chk("t5_win_x", best_mvx[0], MVC_ON ? mv(0) : mv(3));
    lambda = 4'd1;
    beat(1, 1, -64, 0, 10, 10, 0);
    idle(); step(); step();
    chk("t5_min_mv", best_cost[0], MVC_ON ? 64 : 0);
    chk("t5_min_x", best_mvx[0], mv(-64));

    // reset mid-flight drops the search
    beat(1, 1, 2, 2, 255, 0, 0);
    idle(); step();
    rst = 1'b1;
    #1;
    chk("t6_cost_async", best_cost[0], 32'h1FFFF);
    chk("t6_mvx_async", best_mvx[0], 0);
    chk("t6_done_async", done, 0);
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("t6_done%0d", k), done, 0);
    end
    chk("t6_cost0", best_cost[0], 32'h1FFFF);
    chk("t6_cost40", best_cost[40], 32'h1FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ime_sad_tree_min.md
# ime_sad_tree_min

Parametrised, pipelined variable-block-size SAD engine for integer motion estimation.
- Accepts one 16x16 current/reference macroblock pair per cycle, tagged with its candidate motion vector.
- Computes SADs for all 41 H.264 partitions: 4x4, 8x4, 4x8, 8x8, 16x8, 8x16 and 16x16.
- Tracks the minimum-cost candidate per partition across a search window.
- Sits between the IME reference-window fetcher and the mode-decision logic; it replaces the fixed 8-bit, unregistered PE array.

## Interface
Parameters:
- PIX_W, 8, pixel width
- MV_W, 7, signed width of each MV component
- LAMBDA_W, 4, width of the MV-cost multiplier
- SAD_W, PIX_W+8, derived; 16x16 SAD without overflow
- COST_W, SAD_W+1, derived; cost/compare width

Ports:
- clk  in  1  clock; one clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  candidate beat present
- in_first  in  1  first candidate of a search; qualified by in_valid
- in_last  in  1  last candidate of a search; qualified by in_valid
- in_mvx, in_mvy  in  MV_W each  signed candidate MV
- cur  in  PIX_W x [15:0][15:0]  current MB, [row][col]
- ref  in  PIX_W x [15:0][15:0]  reference candidate, [row][col]
- lambda  in  LAMBDA_W  MV-cost weight; port present only with IME_MVCOST_EN
- best_cost  out  COST_W x [40:0]  per-partition minimum cost
- best_mvx, best_mvy  out  MV_W x [40:0]  MV of the minimum
- done  out  1  one-cycle pulse: search results final

## Operation
Partition index:
- 0: 16x16
- 1–2: 16x8, top/bottom
- 3–4: 8x16, left/right
- 5–8: 8x8, quadrant q in raster order
- 9+2q+s: 8x4, s=top/bottom
- 17+2q+s: 4x8, s=left/right
- 25+4q+s: 4x4, s raster within quadrant

Datapath and compare:
- No backpressure; one beat is accepted every cycle that in_valid=1.
- Stage 1: 16 absolute-difference 4x4 sums, each PIX_W+4 bits.
- Stage 2: adder tree to all 41 SADs, full width at every level, never truncated; per-partition cost formed here.
- Stage 3: compare and update.
  - If the beat carried in_first: best := this beat's cost/MV unconditionally.
  - Otherwise: best is replaced only if cost < best_cost, strictly less.
  - Ties keep the earlier candidate.
- in_first and in_last on the same beat is a one-candidate search; done pulses and best holds that beat.
- in_first arriving while an earlier search is in flight: the earlier search's remaining beats still update and pulse done in order; the new search then overwrites at its own first-beat update.
- Beats without any preceding in_first after reset compare against the reset values.
- best_* hold their value between searches; they are valid for the done cycle and stay stable until the next in_first beat reaches stage 3.

## Timing
- Beat sampled at edge k.
- Stage 1 registered at edge k, stage 2 at k+1, best_* and done at k+2.
- done is high for the one cycle after edge k+2 of an in_last beat.
- Full throughput: back-to-back searches give done pulses separated by exactly the beat count.
- Reset values: best_cost all-ones (2^COST_W−1), best_mvx/best_mvy 0, done 0, all stage valids 0.
- Reset asserted mid-search: in-flight beats are discarded, no done pulse, outputs return to reset values immediately (asynchronously).

## Configuration
- IME_MVCOST_EN defined:
  - lambda port exists.
  - cost = sad + lambda*(|mvx|+|mvy|), computed in stage 2.
  - Saturates at 2^COST_W−1.
  - |−2^(MV_W−1)| handled without wrap.
- Undefined: no lambda port; cost = zero-extended SAD.

## Structure
- Package ime_pkg holds:
  - NUM_PART=41
  - partition index constants (P16x16, P16x8_0, …, P4x4_15)
  - typedef part_e
  - the partition-to-4x4 membership function used by the tree
- One sub-module, ime_sad4x4: 16-pixel abs-diff and sum, registered, parametrised on PIX_W; instantiated 16 times.

## Test plan
1. Reset, PIX_W=8 -> all best_cost=0x1FFFF, best_mv 0, done 0.
2. cur=ref=10 everywhere, single beat first+last, mv(0,0) at edge k -> done at k+2, all 41 costs 0.
3. Two-beat search:
   - Beat A: mv(1,0), ref=cur+1 everywhere.
   - Beat B: mv(−2,3), ref=cur except top-left 4x4 +5.
   - Result: idx25=16@(1,0); idx26=0@(−2,3); idx5=64@(1,0); idx0=80@(−2,3).
4. Tie: three beats with identical SAD, mvs (4,4),(0,0),(1,1) -> all partitions report (4,4).
5. cur=255, ref=0, PIX_W=8 -> idx0=65280, idx5=16320, no wrap; with IME_MVCOST_EN, lambda=2, mv(3,−1), zero SAD -> cost 8; a later zero-SAD beat at mv(0,0) wins.
6. Assert rst at cycle k+1 of an in_last beat -> no done pulse, all costs read 0x1FFFF.
